// File: rtl/avalon_pio_ext.sv
// Avalon-MM parallel I/O slave: per-bit direction, atomic set/clear, synchronised
// inputs with sticky edge capture and a maskable level interrupt.
module avalon_pio_ext #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_en,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
    localparam logic [2:0] ARM_COUNT    = 3'(SYNC_STAGES + 1);

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wdata;
    logic             unused_wdata;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] sync_prev;
    logic [2:0]       arm_cnt;
    logic             edge_armed;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] cap_clear;
    logic [31:0]      read_mux;

    assign wr_en        = chipselect & ~write_n;
    assign rd_en        = chipselect & ~read_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    assign sync_in    = sync_chain[SYNC_STAGES-1];
    assign edge_armed = (arm_cnt == ARM_COUNT);

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= '0;
            end
            sync_prev <= '0;
        end else begin
            sync_chain[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= sync_chain[i-1];
            end
            sync_prev <= sync_in;
        end
    end

    // Holds off capture until the chain has flushed, so pins already high
    // at reset release are not mistaken for rising edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt <= '0;
        end else if (!edge_armed) begin
            arm_cnt <= arm_cnt + 3'd1;
        end
    end

    always_comb begin
        edges = '0;
        case (EDGE_TYPE)
            0:       edges = sync_in & ~sync_prev;
            1:       edges = ~sync_in & sync_prev;
            default: edges = sync_in ^ sync_prev;
        endcase
        if (!edge_armed) begin
            edges = '0;
        end
    end

    always_comb begin
        cap_clear = '0;
        if (wr_en && address == ADDR_EDGECAP) begin
            cap_clear = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= OUT_RESET;
            dir      <= DIR_RESET;
            irqmask  <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:    data_out <= wdata;
                ADDR_DIR:     dir      <= wdata;
                ADDR_IRQMASK: irqmask  <= wdata;
                ADDR_OUTSET:  data_out <= data_out | wdata;
                ADDR_OUTCLR:  data_out <= data_out & ~wdata;
                default:      ;
            endcase
        end
    end

    // A new edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~cap_clear) | edges;
        end
    end

    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:    read_mux[WIDTH-1:0] = (sync_in & ~dir) | (data_out & dir);
            ADDR_DIR:     read_mux[WIDTH-1:0] = dir;
            ADDR_IRQMASK: read_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: read_mux[WIDTH-1:0] = edgecap;
            default:      read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= read_mux;
        end
    end

    assign out_port = data_out;
    assign out_en   = dir;
    assign irq      = |(edgecap & irqmask);

endmodule

// File: tb/tb_avalon_pio_ext.sv
// Bench for avalon_pio_ext: two configurations on one shared bus, checked every
// cycle against a pin-history reference model plus directed constant checks.
module tb_avalon_pio_ext;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [7:0]  in_port = '0;

    logic [31:0] rd_a, rd_b;
    logic [7:0]  out_a, out_b, en_a, en_b;
    logic        irq_a, irq_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_pio_ext #(
        .WIDTH(8), .OUT_RESET(8'hA5), .DIR_RESET(8'hF0), .SYNC_STAGES(2), .EDGE_TYPE(0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd_a),
        .in_port(in_port), .out_port(out_a), .out_en(en_a), .irq(irq_a)
    );

    avalon_pio_ext #(
        .WIDTH(8), .OUT_RESET(8'h00), .DIR_RESET(8'h00), .SYNC_STAGES(3), .EDGE_TYPE(2)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd_b),
        .in_port(in_port), .out_port(out_b), .out_en(en_b), .irq(irq_b)
    );

    // Reference model: registers per configuration, plus the pin value seen at
    // every clock edge since reset release (hist[1] is the first edge).
    int          s_of   [2] = '{2, 3};
    int          et_of  [2] = '{0, 2};
    logic [7:0]  rst_out[2] = '{8'hA5, 8'h00};
    logic [7:0]  rst_dir[2] = '{8'hF0, 8'h00};
    logic [7:0]  m_dout [2];
    logic [7:0]  m_dir  [2];
    logic [7:0]  m_mask [2];
    logic [7:0]  m_ecap [2];
    logic [31:0] m_rd   [2];
    logic [7:0]  hist   [0:4095];
    int          t;
    logic [7:0]  pin = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pin value visible on sync_in after edge k of configuration d.
    function automatic logic [7:0] sync_at(input int d, input int k);
        int idx;
        idx = k - s_of[d] + 1;
        if (idx < 1) return 8'h00;
        return hist[idx];
    endfunction

    task automatic model_reset();
        t = 0;
        for (int d = 0; d < 2; d++) begin
            m_dout[d] = rst_out[d];
            m_dir[d]  = rst_dir[d];
            m_mask[d] = 8'h00;
            m_ecap[d] = 8'h00;
            m_rd[d]   = 32'h0;
        end
    endtask

    task automatic model_step(input bit c, input bit w, input bit r,
                              input logic [2:0] a, input logic [31:0] wd);
        logic [7:0] cur, prv, ed, clr, wb;
        t++;
        hist[t] = pin;
        wb = wd[7:0];
        for (int d = 0; d < 2; d++) begin
            cur = sync_at(d, t - 1);
            prv = sync_at(d, t - 2);
            if (c && r) begin
                case (a)
                    3'd0:    m_rd[d] = {24'h0, (cur & ~m_dir[d]) | (m_dout[d] & m_dir[d])};
                    3'd1:    m_rd[d] = {24'h0, m_dir[d]};
                    3'd2:    m_rd[d] = {24'h0, m_mask[d]};
                    3'd3:    m_rd[d] = {24'h0, m_ecap[d]};
                    default: m_rd[d] = 32'h0;
                endcase
            end
            if (et_of[d] == 0)      ed = cur & ~prv;
            else if (et_of[d] == 1) ed = ~cur & prv;
            else                    ed = cur ^ prv;
            if (t < s_of[d] + 2) ed = 8'h00;
            clr = 8'h00;
            if (c && w) begin
                case (a)
                    3'd0: m_dout[d] = wb;
                    3'd1: m_dir[d]  = wb;
                    3'd2: m_mask[d] = wb;
                    3'd3: clr       = wb;
                    3'd4: m_dout[d] = m_dout[d] | wb;
                    3'd5: m_dout[d] = m_dout[d] & ~wb;
                    default: ;
                endcase
            end
            m_ecap[d] = (m_ecap[d] & ~clr) | ed;
        end
    endtask

    task automatic compare_all();
        check_eq("rd_a",  rd_a,  m_rd[0]);
        check_eq("out_a", {24'h0, out_a}, {24'h0, m_dout[0]});
        check_eq("en_a",  {24'h0, en_a},  {24'h0, m_dir[0]});
        check_eq("irq_a", {31'h0, irq_a}, {31'h0, |(m_ecap[0] & m_mask[0])});
        check_eq("rd_b",  rd_b,  m_rd[1]);
        check_eq("out_b", {24'h0, out_b}, {24'h0, m_dout[1]});
        check_eq("en_b",  {24'h0, en_b},  {24'h0, m_dir[1]});
        check_eq("irq_b", {31'h0, irq_b}, {31'h0, |(m_ecap[1] & m_mask[1])});
    endtask

    task automatic tick(input bit c, input bit w, input bit r,
                        input logic [2:0] a, input logic [31:0] wd);
        chipselect = c;
        write_n    = !w;
        read_n     = !r;
        address    = a;
        writedata  = wd;
        in_port    = pin;
        @(posedge clk);
        model_step(c, w, r, a, wd);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        tick(1'b1, 1'b1, 1'b0, a, wd);
    endtask

    task automatic rd(input logic [2:0] a);
        tick(1'b1, 1'b0, 1'b1, a, 32'h0);
    endtask

    // Enters reset with a DATA write pending so an aborted write is exercised.
    task automatic do_reset();
        chipselect = 1'b1;
        write_n    = 1'b0;
        read_n     = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0000_00FF;
        in_port    = pin;
        #2 reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        check_eq("rst_out_a", {24'h0, out_a}, 32'h0000_00A5);
        check_eq("rst_en_a",  {24'h0, en_a},  32'h0000_00F0);
        check_eq("rst_rd_a",  rd_a, 32'h0);
        check_eq("rst_irq_a", {31'h0, irq_a}, 32'h0);

        rd(3'd1);
        check_eq("dir_read_a", rd_a, 32'h0000_00F0);

        wr(3'd0, 32'h0000_000F);
        check_eq("data_wr", {24'h0, out_a}, 32'h0000_000F);
        wr(3'd4, 32'h0000_0030);
        check_eq("outset", {24'h0, out_a}, 32'h0000_003F);
        wr(3'd5, 32'h0000_0005);
        check_eq("outclr", {24'h0, out_a}, 32'h0000_003A);
        rd(3'd4);
        check_eq("outset_rd", rd_a, 32'h0);
        rd(3'd5);
        check_eq("outclr_rd", rd_a, 32'h0);

        wr(3'd1, 32'h0000_0000);
        pin = 8'h81;
        idle(4);
        rd(3'd0);
        check_eq("data_in", rd_a, 32'h0000_0081);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd0, 32'hFFFF_FF3C);
        rd(3'd0);
        check_eq("data_out_rd", rd_a, 32'h0000_003C);
        rd(3'd1);
        check_eq("upper_zero", rd_a, 32'h0000_00FF);

        pin = 8'h00;
        idle(5);
        wr(3'd3, 32'h0000_00FF);
        wr(3'd2, 32'h0000_0001);
        pin = 8'h01;
        idle(1);
        check_eq("irq_early1", {31'h0, irq_a}, 32'h0);
        idle(1);
        check_eq("irq_early2", {31'h0, irq_a}, 32'h0);
        idle(1);
        check_eq("irq_rise", {31'h0, irq_a}, 32'h1);
        rd(3'd3);
        check_eq("ecap_rise", rd_a, 32'h0000_0001);
        wr(3'd3, 32'h0000_0001);
        check_eq("irq_clr", {31'h0, irq_a}, 32'h0);
        pin = 8'h00;
        idle(5);
        check_eq("irq_fall", {31'h0, irq_a}, 32'h0);
        rd(3'd3);
        check_eq("ecap_fall", rd_a, 32'h0);

        wr(3'd2, 32'h0000_0000);
        pin = 8'h04;
        idle(2);
        wr(3'd3, 32'h0000_0004);
        rd(3'd3);
        check_eq("set_wins", rd_a & 32'h4, 32'h4);
        check_eq("masked_irq", {31'h0, irq_a}, 32'h0);

        wr(3'd3, 32'h0000_00FF);
        idle(3);
        wr(3'd3, 32'h0000_00FF);
        pin = 8'h02;
        idle(3);
        pin = 8'h00;
        idle(5);
        rd(3'd3);
        check_eq("pulse_b", rd_b & 32'h2, 32'h2);
        wr(3'd3, 32'h0000_00FF);
        pin = 8'h02;
        idle(1);
        do_reset();
        check_eq("rst_ecap_irq_b", {31'h0, irq_b}, 32'h0);
        idle(8);
        rd(3'd3);
        check_eq("no_cap_a", rd_a, 32'h0);
        check_eq("no_cap_b", rd_b, 32'h0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
            if (i == 750) begin
                do_reset();
            end else begin
                tick(1'($urandom_range(0, 5) != 0), 1'($urandom), 1'($urandom),
                     3'($urandom_range(0, 7)), $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_pio_ext.md
# avalon_pio_ext

Parametrised Avalon-MM parallel I/O slave for the qlab system interconnect. Provides WIDTH bidirectional-capable pins with a per-bit direction register, atomic output set/clear, synchronised input sampling, edge capture and a maskable level interrupt to the processor. It sits between the system bus fabric and board-level pins/LEDs/switches.

## Interface
- WIDTH, 8, number of I/O bits (1..32); bus bits above WIDTH read 0, writes ignored
- OUT_RESET, 0, reset value of output data register (WIDTH bits)
- DIR_RESET, 0, reset value of direction register (1 = output)
- SYNC_STAGES, 2, input synchroniser depth (2..4)
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  word address of register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- read_n  in  1  active-low read strobe, qualified by chipselect
- writedata  in  32  write data
- readdata  out  32  registered read data, read latency 1
- in_port  in  WIDTH  pin input (asynchronous to clk)
- out_port  out  WIDTH  output data register
- out_en  out  WIDTH  per-bit output enable (= direction register)
- irq  out  1  level interrupt, active-high

## Operation
- Register map (word address):
  - 0 DATA: write loads data_out; read returns (sync_in & ~dir) | (data_out & dir)
  - 1 DIR: read/write direction, 1 = output
  - 2 IRQMASK: read/write interrupt mask, reset 0
  - 3 EDGECAP: read returns capture bits; write clears bits where writedata = 1
  - 4 OUTSET: write data_out |= writedata; read returns 0
  - 5 OUTCLR: write data_out &= ~writedata; read returns 0
  - 6, 7 reserved: read 0, writes ignored
- Write occurs on clk edge where chipselect = 1 and write_n = 0. Simultaneous read_n = 0 and write_n = 0: write performed, readdata returns pre-write value.
- in_port passes through SYNC_STAGES flops to sync_in; one further flop holds sync_prev.
- Edge detect per bit: rising = sync_in & ~sync_prev; falling = ~sync_in & sync_prev; any = XOR. Applies to all bits regardless of DIR.
- edgecap[i] set on detected edge, cleared only by EDGECAP write of 1 or reset. Same-cycle edge and clear: set wins (bit remains 1).
- irq = |(edgecap & irqmask), combinational from registers (no extra latency).
- Reset: out_port = OUT_RESET, out_en = DIR_RESET, irqmask = 0, edgecap = 0, synchroniser and sync_prev = 0, readdata = 0, irq = 0.
- Edge detection suppressed for the first SYNC_STAGES+1 cycles after reset release, so pins high at reset do not raise spurious rising captures.

## Timing
- Write: register updates at the accepting clk edge; out_port/out_en visible immediately after that edge.
- Read: request sampled at edge k; readdata valid after edge k, held until next accepted read.
- Input: in_port change sampled at edge n appears on sync_in after edge n+SYNC_STAGES-1; edgecap bit and irq (if masked in) assert after edge n+SYNC_STAGES.
- Reading DATA for an input bit reflects sync_in at the read-accept edge.
- irq deasserts the cycle after an EDGECAP clear write or IRQMASK bit clear.
- Asynchronous reset mid-transaction aborts it; no partial register update.

## Test plan
- Reset with WIDTH=8, OUT_RESET=8'hA5, DIR_RESET=8'hF0 -> out_port=A5, out_en=F0, readdata=0, irq=0; read DIR -> 0x000000F0 one cycle after read.
- Write DATA=0x0F, OUTSET=0x30, OUTCLR=0x05 -> out_port 0F, 3F, 3A after each write edge; reads of OUTSET/OUTCLR return 0.
- DIR=0x00, in_port=0x81 held -> read DATA returns 0x81; DIR=0xFF, data_out=0x3C -> read DATA returns 0x3C; upper 24 bits always 0.
- EDGE_TYPE=0, IRQMASK=0x01, in_port[0] 0->1 -> EDGECAP=0x01 and irq=1 exactly SYNC_STAGES+1 edges after sampling; write EDGECAP=0x01 -> irq=0 next cycle; 1->0 transition raises nothing.
- Edge on bit 2 coinciding with EDGECAP write 0x04 -> bit 2 stays 1; masked-out edges (IRQMASK=0) set EDGECAP but irq stays 0.
- EDGE_TYPE=2, SYNC_STAGES=3, pulse in_port[1] high 3 cycles -> EDGECAP bit 1 set once; assert reset_n low mid-pulse -> all state cleared, no capture after release with pin already high.
